fpc_enc_tx: RTL
===============

# fpc_enc_tx

Transmit-side forbidden-pattern-condition (FPC) stage that sits directly upstream of the FPC decoder across the crosstalk-sensitive bus. It accepts parallel data words over a valid/ready handshake, splits each word into 4-bit nibbles (MSB nibble first), and maps each nibble to its 5-bit FPC codeword. It drives one registered codeword per cycle onto the bus under a second valid/ready handshake, and marks the final codeword of each word.

## Interface
- NIBBLES, 4, nibbles per input word (legal range 1..8); input width is 4*NIBBLES.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  4*NIBBLES  parallel word to encode; nibble NIBBLES-1 (MSBs) goes first.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block accepts data_in this cycle (combinational).
- data_out  output  5  registered FPC codeword on the bus.
- out_valid  output  1  data_out holds a codeword to be consumed.
- out_ready  input  1  downstream consumes data_out this cycle.
- out_last  output  1  data_out is the final codeword of the current word.

## Operation
- Codebook (nibble -> codeword):
  - 0->00000, 1->00001, 2->00110, 3->00011, 4->01100, 5->00111, 6->01110, 7->01111
  - 8->10000, 9->10001, A->11000, B->10011, C->11100, D->11001, E->11110, F->11111
  - Must match the decoder exactly; no other codewords are ever driven while out_valid=1.
- FSM states:
  - IDLE: out_valid=0.
  - SEND: out_valid=1.
- Internal state: shift register holding the nibbles not yet sent, and a nibble index cnt (0..NIBBLES-1) for the codeword currently on the bus.
- Input acceptance: in_ready = !rst && (state==IDLE || (out_ready && out_last)). A transfer occurs on any edge where in_valid && in_ready.
- On an input transfer:
  - data_out <= enc(data_in[4*NIBBLES-1 -: 4]), cnt <= 0, out_valid <= 1, out_last <= (NIBBLES==1).
  - The remaining nibbles are loaded into the shift register; state becomes SEND.
- In SEND with out_ready=1 and out_last=0: data_out <= enc(next nibble), cnt <= cnt+1, out_last <= (cnt+1 == NIBBLES-1).
- In SEND with out_ready=1 and out_last=1:
  - If an input transfer occurs in the same cycle, load the new word as above. There is no bubble; the next word's first codeword follows immediately.
  - Otherwise go to IDLE with out_valid <= 0 and out_last <= 0. data_out takes its idle value (see Configuration).
- In SEND with out_ready=0: data_out, cnt, out_last and the shift register hold. data_out must not change while out_valid=1 and out_ready=0.
- in_valid has no effect while in_ready=0; data_in is sampled only on a transfer.

## Timing
- Reset (asynchronous, immediate): state IDLE, data_out=5'b00000, out_valid=0, out_last=0, cnt=0, shift register=0. in_ready=0 while rst=1, and 1 on the first cycle after release.
- Latency: a word accepted at edge N has its first codeword valid after edge N. Its last codeword is valid after edge N+NIBBLES-1 when out_ready is held high.
- Throughput: one word per NIBBLES cycles sustained, with no idle cycle between back-to-back words.
- Reset mid-word aborts the word. Remaining nibbles are discarded and not resumed.
- NIBBLES=1: every codeword has out_last=1, and in_ready follows out_ready while in SEND.

## Configuration
- FPC_IDLE_HOLD_EN defined: on SEND->IDLE, data_out keeps the last transmitted codeword, so the bus does not toggle while idle.
- FPC_IDLE_HOLD_EN undefined: on SEND->IDLE, data_out is driven to 5'b00000.
- The macro affects the idle value of data_out only. Handshake and codeword timing are identical in both builds.

## Test plan
- Reset: assert rst mid-cycle with out_valid=1 -> data_out=00000, out_valid=0, out_last=0 immediately, and in_ready=0 until release.
- Single word, NIBBLES=4, data_in=16'h2A5C, out_ready=1 -> codewords 00110, 11000, 00111, 11100 on consecutive cycles, out_last=1 only on 11100, then out_valid=0.
- Backpressure: same word with out_ready=0 for 3 cycles on the second codeword -> 11000 held stable for 3 cycles, in_ready=0 throughout, and the sequence resumes unchanged.
- Back-to-back: 16'h0123 then 16'hFEDC with in_valid high -> eight codewords with no bubble: 00000, 00001, 00110, 00011, 11111, 11110, 11001, 11100.
- Idle value: after 16'h00F7 completes (last codeword 01111) -> data_out stays 01111 with FPC_IDLE_HOLD_EN defined, and becomes 00000 without it.
- Round trip: all 16 nibble values through NIBBLES=1 into the decoder -> decoder output equals the input nibble every time, with no default-case hit.

Source files
------------

// File: rtl/fpc_enc_tx.sv
`default_nettype none
// ============================================================================
// Module      : fpc_enc_tx
// Description : Transmit-side FPC encoder. Splits each accepted word into
//               nibbles (MSB nibble first), maps every nibble to its 5-bit
//               forbidden-pattern-free codeword and drives one registered
//               codeword per cycle under a valid/ready handshake, flagging
//               the last codeword of each word.
//               Build option FPC_IDLE_HOLD_EN: when defined, data_out keeps
//               the last codeword while idle; otherwise it returns to 00000.
// Revision    : 1.0 - initial release
// ============================================================================
module fpc_enc_tx #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4*NIBBLES-1:0] data_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [4:0]           data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam int W     = 4 * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [4:0]         r_data;
   logic [4:0]         w_data_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_last;
   logic               w_last_nxt;
   logic [W-1:0]       r_shreg;
   logic [W-1:0]       w_shreg_nxt;
   logic               w_take;

   // Nibble to codeword map; must stay identical to the decoder's table.
   function automatic logic [4:0] enc(input logic [3:0] nib);
      logic [4:0] cw;
      case (nib)
         4'h0:    cw = 5'b00000;
         4'h1:    cw = 5'b00001;
         4'h2:    cw = 5'b00110;
         4'h3:    cw = 5'b00011;
         4'h4:    cw = 5'b01100;
         4'h5:    cw = 5'b00111;
         4'h6:    cw = 5'b01110;
         4'h7:    cw = 5'b01111;
         4'h8:    cw = 5'b10000;
         4'h9:    cw = 5'b10001;
         4'hA:    cw = 5'b11000;
         4'hB:    cw = 5'b10011;
         4'hC:    cw = 5'b11100;
         4'hD:    cw = 5'b11001;
         4'hE:    cw = 5'b11110;
         default: cw = 5'b11111;
      endcase
      return cw;
   endfunction

   // A new word may enter when idle, or when the last codeword leaves now.
   assign in_ready  = !rst && ((r_state == IDLE) || (out_ready && r_last));
   assign w_take    = in_valid && in_ready;
   assign out_valid = (r_state == SEND);
   assign data_out  = r_data;
   assign out_last  = r_last;

   // Next-state and datapath: load a word, step to the next nibble, or go idle.
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      w_shreg_nxt = r_shreg;
      case (r_state)
         IDLE: begin
            if (w_take) begin
               w_state_nxt = SEND;
               w_data_nxt  = enc(data_in[W-1 -: 4]);
               w_cnt_nxt   = '0;
               w_last_nxt  = (NIBBLES == 1);
               w_shreg_nxt = data_in << 4;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (!r_last) begin
                  w_data_nxt  = enc(r_shreg[W-1 -: 4]);
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                  w_last_nxt  = ((32'(r_cnt) + 32'd1) == 32'(NIBBLES - 1));
                  w_shreg_nxt = r_shreg << 4;
               end else if (w_take) begin
                  // Back-to-back word: first codeword follows with no bubble.
                  w_state_nxt = SEND;
                  w_data_nxt  = enc(data_in[W-1 -: 4]);
                  w_cnt_nxt   = '0;
                  w_last_nxt  = (NIBBLES == 1);
                  w_shreg_nxt = data_in << 4;
               end else begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
                  w_last_nxt  = 1'b0;
`ifdef FPC_IDLE_HOLD_EN
                  // Keep the bus quiet: the last codeword stays put.
                  w_data_nxt  = r_data;
`else
                  w_data_nxt  = 5'b00000;
`endif
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= 5'b00000;
         r_cnt   <= '0;
         r_last  <= 1'b0;
         r_shreg <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_shreg <= w_shreg_nxt;
      end
   end

endmodule
`default_nettype wire
